iq_dc_pair_conditioner: RTL
===========================

Name: iq_dc_pair_conditioner

Overview:
- Sits between the I/Q CIC decimators and the I/Q data serializers, in the sx1257_clk_out domain.
- Pairs the independent I and Q decimator output strobes into one aligned I/Q sample.
- Removes DC offset per channel with a leaky-integrator mean estimate.
- Gates output on stream enable and presents each pair on a single valid/ready output with drop accounting.

Parameters:
- IN_WIDTH, 13, width of unsigned CIC sample inputs.
- OUT_WIDTH, 13, width of signed (two's complement) conditioned outputs.
- DC_SHIFT, 8, leaky-integrator shift K; accumulator width IN_WIDTH+DC_SHIFT.
- CNT_WIDTH, 8, width of overflow counter.

Ports:
- clk  in  1  sample clock (sx1257_clk_out).
- rst  in  1  asynchronous, active-high reset.
- i_tdata  in  IN_WIDTH  I CIC output, unsigned.
- i_tvalid  in  1  I sample strobe, one cycle.
- q_tdata  in  IN_WIDTH  Q CIC output, unsigned.
- q_tvalid  in  1  Q sample strobe, one cycle.
- stream_en  in  1  synchronized stream enable.
- out_i_tdata  out  OUT_WIDTH  DC-removed I, signed.
- out_q_tdata  out  OUT_WIDTH  DC-removed Q, signed.
- out_tvalid  out  1  output pair valid.
- out_tready  in  1  consumer ready.
- pair_error  out  1  one-cycle pulse: unpaired sample overwritten.
- overflow_count  out  CNT_WIDTH  pairs dropped due to backpressure; saturates at all-ones.

Behaviour:
- Reset (async assert): all outputs 0; hold flags clear; accumulators 0; seeded flag clear.
- Pairing stage:
  - i_tvalid loads i_hold and sets i_flag; q_tvalid does the same for Q.
  - When both flags are set (registered), a pair forms that cycle and both flags clear.
  - Both strobes in the same cycle: the pair forms the next cycle.
  - i_tvalid while i_flag=1 and q_flag=0: i_hold is overwritten, pair_error pulses, no pair forms. Q is symmetric.
  - Strobe arriving in the same cycle a pair forms: loads its hold register and sets its flag for the next pair; it is not lost.
- DC stage, per channel, on each formed pair (cycle P):
  - m = acc >> DC_SHIFT, using acc before update.
  - y = x − m, computed at IN_WIDTH+1 bits signed.
  - acc ← acc + x − m.
  - First pair after reset (seeded=0): acc ← x << DC_SHIFT, y = 0, seeded ← 1.
  - The estimator updates on every pair regardless of stream_en or backpressure.
- Output conversion: y reduced to OUT_WIDTH per the optional feature.
- Gating: stream_en sampled at cycle P. If 0, the pair is discarded silently: no output, no count.
- Output register:
  - Result ready at P+1; out_tvalid rises at P+2. Latency from the later input strobe = 3 cycles.
  - Transfer occurs when out_tvalid && out_tready.
  - Data is stable while out_tvalid && !out_tready.
  - New result arriving while out_tvalid=1 and out_tready=0: new result dropped, overflow_count increments (saturating), held data unchanged.
  - New result in the same cycle as a transfer: loads directly; out_tvalid stays 1.
- Reset mid-operation: all state clears immediately; a pending output is lost; seeding repeats on the next pair.

Optional Feature:
- Macro: IQ_DC_SATURATE_EN.
- Defined: y clamps to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1], i.e. [−4096, 4095] by default.
- Undefined: y wraps; out = low OUT_WIDTH bits of y.

Test Plan:
- Reset, then simultaneous I/Q strobes with I=4096, Q=100, stream_en=1 -> out_tvalid 3 cycles after the strobes, I=0, Q=0 (seeded); overflow_count=0.
- After seed at 0, I strobe with 8191, Q strobe with 0 three cycles later -> I out = 4095 with IQ_DC_SATURATE_EN, −1 (13'h1FFF) without; Q out = 0.
- Two I strobes with no Q between them -> pair_error pulses once; the next Q pairs with the second I value.
- Seed I=0, then 256 pairs of I=256 with DC_SHIFT=8 -> first post-seed I out = 256; outputs decrease monotonically toward 0.
- out_tready=0 held across 5 formed pairs -> first pair held unchanged, overflow_count=4; at 255 further drops it stays 255.
- stream_en=0 for 3 pairs, then 1 -> no outputs during disable; the first enabled output reflects the mean updated by the 3 gated pairs.

Source files
------------

// File: rtl/iq_dc_pair_conditioner.sv
// iq_dc_pair_conditioner
// Pairs the independent I and Q CIC output strobes into one aligned sample,
// removes DC per channel with a leaky-integrator mean estimate, gates the
// pair on stream_en and presents it on a registered valid/ready output.
// Configuration macro: IQ_DC_SATURATE_EN (defined: clamp the DC-removed
// result to OUT_WIDTH; undefined: keep its low OUT_WIDTH bits).
module iq_dc_pair_conditioner #(
    parameter int IN_WIDTH  = 13,
    parameter int OUT_WIDTH = 13,
    parameter int DC_SHIFT  = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  i_tdata,
    input  logic                 i_tvalid,
    input  logic [IN_WIDTH-1:0]  q_tdata,
    input  logic                 q_tvalid,
    input  logic                 stream_en,
    output logic [OUT_WIDTH-1:0] out_i_tdata,
    output logic [OUT_WIDTH-1:0] out_q_tdata,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic                 pair_error,
    output logic [CNT_WIDTH-1:0] overflow_count
);

    localparam int ACC_W = IN_WIDTH + DC_SHIFT;
    localparam int Y_W   = IN_WIDTH + 1;

    // Pairing stage state
    logic [IN_WIDTH-1:0] i_hold_q, q_hold_q;
    logic                i_flag_q, q_flag_q;
    logic                pair_error_q;
    logic                pair_fire;

    // DC estimator state and next-state values
    logic [ACC_W-1:0]        i_acc_q, q_acc_q, i_acc_d, q_acc_d;
    logic [IN_WIDTH-1:0]     i_mean, q_mean;
    logic signed [Y_W-1:0]   i_y_d, q_y_d;
    logic                    seeded_q;

    // Result register (P+1) and output register (P+2)
    logic [OUT_WIDTH-1:0] res_i_q, res_q_q;
    logic                 res_valid_q;
    logic [OUT_WIDTH-1:0] out_i_q, out_q_q;
    logic                 out_valid_q;
    logic [CNT_WIDTH-1:0] ovf_q;

    // Reduce the IN_WIDTH+1 signed difference to the output width.
    function automatic logic [OUT_WIDTH-1:0] reduce_y(input logic signed [Y_W-1:0] y);
`ifdef IQ_DC_SATURATE_EN
        localparam logic signed [Y_W-1:0] Y_MAX = Y_W'((2 ** (OUT_WIDTH - 1)) - 1);
        localparam logic signed [Y_W-1:0] Y_MIN = Y_W'(-(2 ** (OUT_WIDTH - 1)));
        if (y > Y_MAX) return OUT_WIDTH'(Y_MAX);
        if (y < Y_MIN) return OUT_WIDTH'(Y_MIN);
        return OUT_WIDTH'(y);
`else
        return OUT_WIDTH'(y);
`endif
    endfunction

    // A pair forms in the cycle both registered flags are set.
    assign pair_fire = i_flag_q & q_flag_q;

    // Capture strobes into hold registers, track flags, flag overwritten unpaired samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_hold_q     <= '0;
            q_hold_q     <= '0;
            i_flag_q     <= 1'b0;
            q_flag_q     <= 1'b0;
            pair_error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // flag values, so a strobe in the pairing cycle reloads the hold
            // register only after the pair has consumed the old value.
            if (i_tvalid) i_hold_q <= i_tdata;
            if (q_tvalid) q_hold_q <= q_tdata;
            i_flag_q     <= i_tvalid | (i_flag_q & ~pair_fire);
            q_flag_q     <= q_tvalid | (q_flag_q & ~pair_fire);
            pair_error_q <= (i_tvalid & i_flag_q & ~q_flag_q)
                          | (q_tvalid & q_flag_q & ~i_flag_q);
        end
    end

    // Leaky-integrator mean, DC-removed sample and next accumulator per channel.
    always_comb begin
        // NOTE: every output gets its seed-case value first so no path can
        // leave a variable unassigned and infer a latch.
        i_mean  = i_acc_q[ACC_W-1:DC_SHIFT];
        q_mean  = q_acc_q[ACC_W-1:DC_SHIFT];
        i_y_d   = '0;
        q_y_d   = '0;
        i_acc_d = {i_hold_q, {DC_SHIFT{1'b0}}};
        q_acc_d = {q_hold_q, {DC_SHIFT{1'b0}}};
        if (seeded_q) begin
            i_y_d   = $signed({1'b0, i_hold_q}) - $signed({1'b0, i_mean});
            q_y_d   = $signed({1'b0, q_hold_q}) - $signed({1'b0, q_mean});
            i_acc_d = i_acc_q + ACC_W'(i_hold_q) - ACC_W'(i_mean);
            q_acc_d = q_acc_q + ACC_W'(q_hold_q) - ACC_W'(q_mean);
        end
    end

    // Update the estimator on every pair; register the result only when streaming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_acc_q     <= '0;
            q_acc_q     <= '0;
            seeded_q    <= 1'b0;
            res_i_q     <= '0;
            res_q_q     <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (pair_fire) begin
                i_acc_q  <= i_acc_d;
                q_acc_q  <= q_acc_d;
                seeded_q <= 1'b1;
                res_i_q  <= reduce_y(i_y_d);
                res_q_q  <= reduce_y(q_y_d);
            end
            res_valid_q <= pair_fire & stream_en;
        end
    end

    // Output register: hold under backpressure, drop and count new results that collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= '0;
        end else if (res_valid_q) begin
            if (out_valid_q && !out_tready) begin
                if (ovf_q != '1) ovf_q <= ovf_q + 1'b1;
            end else begin
                out_i_q     <= res_i_q;
                out_q_q     <= res_q_q;
                out_valid_q <= 1'b1;
            end
        end else if (out_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_i_tdata    = out_i_q;
    assign out_q_tdata    = out_q_q;
    assign out_tvalid     = out_valid_q;
    assign pair_error     = pair_error_q;
    assign overflow_count = ovf_q;

endmodule
